// File: rtl/pcie_cfg_req_ctrl.sv
// Root-port config request engine: one CfgRd/CfgWr at a time as a Type0/Type1 TLP on the RQ stream.
// Define PCIE_CFG_CRS_RETRY_EN to re-issue on CRS completions; otherwise CRS is reported at once.
module pcie_cfg_req_ctrl #(
  parameter logic [15:0] REQUESTER_ID        = 16'h10EE,
  parameter int          C_DATA_WIDTH        = 128,
  parameter int          KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int          AXI4_RQ_TUSER_WIDTH = 60,
  parameter int          CPL_TIMEOUT         = 50000,
  parameter int          MAX_RETRY           = 8,
  parameter int          RETRY_DELAY         = 1024
) (
  input  logic                           user_clk,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic                           cmd_type1,
  input  logic [15:0]                    cmd_bdf,
  input  logic [9:0]                     cmd_reg,
  input  logic [3:0]                     cmd_be,
  input  logic [31:0]                    cmd_wdata,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic                           s_axis_rq_tlast,
  output logic                           s_axis_rq_tvalid,
  input  logic                           s_axis_rq_tready,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  output logic                           config_mode,
  input  logic                           cpl_sc,
  input  logic                           cpl_ur,
  input  logic                           cpl_crs,
  input  logic                           cpl_ca,
  input  logic                           cpl_mismatch,
  input  logic [31:0]                    cpl_data,
  output logic                           rsp_valid,
  output logic [2:0]                     rsp_status,
  output logic [31:0]                    rsp_data,
  output logic                           busy
);

  // state      | meaning
  // IDLE       | ready for a command
  // SEND_HDR   | header beat on RQ, held until tready
  // SEND_DATA  | CfgWr payload beat
  // WAIT_CPL   | waiting for decoder status, timeout running
  // RETRY_WAIT | back-off after CRS before re-issue
  // RESP       | one-cycle response pulse
  typedef enum logic [2:0] {
    IDLE,
    SEND_HDR,
    SEND_DATA,
    WAIT_CPL,
`ifdef PCIE_CFG_CRS_RETRY_EN
    RETRY_WAIT,
`endif
    RESP
  } state_t;

  localparam int TW = $clog2(CPL_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              write_q, type1_q;
  logic [15:0]       bdf_q;
  logic [9:0]        reg_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [7:0]        tag;
  logic [TW-1:0]     timer;
  logic [2:0]        status_q, status_nxt;
  logic [31:0]       data_q, data_nxt;
  logic              rsp_load;
  logic [127:0]      beat;
  logic              unused_sig;

`ifdef PCIE_CFG_CRS_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int DW = $clog2(RETRY_DELAY + 1);
  logic [RW-1:0] retry_cnt;
  logic [DW-1:0] delay;
`endif

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    rsp_load         = 1'b0;
    status_nxt       = 3'd0;
    data_nxt         = 32'd0;
    beat             = 128'd0;
    s_axis_rq_tkeep  = '0;
    s_axis_rq_tlast  = 1'b0;
    s_axis_rq_tvalid = 1'b0;
    s_axis_rq_tuser  = '0;
    case (state)
      IDLE: if (cmd_valid) state_nxt = SEND_HDR;
      SEND_HDR: begin
        s_axis_rq_tvalid = 1'b1;
        s_axis_rq_tkeep  = KEEP_WIDTH'(4'hF);
        s_axis_rq_tlast  = !write_q;
        s_axis_rq_tuser  = AXI4_RQ_TUSER_WIDTH'(be_q);
        beat = {1'b0, 3'b000, 3'b000, 1'b1, bdf_q, tag,
                REQUESTER_ID, 1'b0, 2'b10, type1_q, write_q, 11'd1,
                32'd0,
                20'd0, reg_q, 2'b00};
        if (s_axis_rq_tready) state_nxt = write_q ? SEND_DATA : WAIT_CPL;
      end
      SEND_DATA: begin
        s_axis_rq_tvalid = 1'b1;
        s_axis_rq_tkeep  = KEEP_WIDTH'(4'h1);
        s_axis_rq_tlast  = 1'b1;
        s_axis_rq_tuser  = AXI4_RQ_TUSER_WIDTH'(be_q);
        beat             = {96'd0, wdata_q};
        if (s_axis_rq_tready) state_nxt = WAIT_CPL;
      end
      WAIT_CPL: begin
        // Completion beats mismatch beats timeout; mismatch never ends the wait.
        if (cpl_sc) begin
          rsp_load = 1'b1;
          data_nxt = write_q ? 32'd0 : cpl_data;
        end else if (cpl_ur) begin
          rsp_load   = 1'b1;
          status_nxt = 3'd1;
        end else if (cpl_ca) begin
          rsp_load   = 1'b1;
          status_nxt = 3'd4;
        end else if (cpl_crs) begin
`ifdef PCIE_CFG_CRS_RETRY_EN
          if (retry_cnt < RW'(MAX_RETRY)) begin
            state_nxt = RETRY_WAIT;
          end else begin
            rsp_load   = 1'b1;
            status_nxt = 3'd2;
          end
`else
          rsp_load   = 1'b1;
          status_nxt = 3'd2;
`endif
        end else if (timer == '0) begin
          rsp_load   = 1'b1;
          status_nxt = 3'd7;
        end
        if (rsp_load) state_nxt = RESP;
      end
`ifdef PCIE_CFG_CRS_RETRY_EN
      RETRY_WAIT: if (delay == '0) state_nxt = SEND_HDR;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q  <= 1'b0;
      type1_q  <= 1'b0;
      bdf_q    <= 16'd0;
      reg_q    <= 10'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
      tag      <= 8'd0;
      timer    <= '0;
      status_q <= 3'd0;
      data_q   <= 32'd0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        write_q <= cmd_write;
        type1_q <= cmd_type1;
        bdf_q   <= cmd_bdf;
        reg_q   <= cmd_reg;
        be_q    <= cmd_be;
        wdata_q <= cmd_wdata;
      end
      if (state == RESP) tag <= tag + 8'd1;
`ifdef PCIE_CFG_CRS_RETRY_EN
      if (state == RETRY_WAIT && delay == '0) tag <= tag + 8'd1;
`endif
      // Down-counter reloads outside WAIT_CPL so every entry starts fresh.
      timer <= (state == WAIT_CPL) ? timer - TW'(1) : TW'(CPL_TIMEOUT - 1);
      if (rsp_load) begin
        status_q <= status_nxt;
        data_q   <= data_nxt;
      end
    end
  end

`ifdef PCIE_CFG_CRS_RETRY_EN
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= '0;
      delay     <= '0;
    end else begin
      if (state == IDLE && cmd_valid) retry_cnt <= '0;
      if (state == RETRY_WAIT && delay == '0) retry_cnt <= retry_cnt + RW'(1);
      delay <= (state == RETRY_WAIT) ? delay - DW'(1) : DW'(RETRY_DELAY - 1);
    end
  end
  assign unused_sig = cpl_mismatch;
`else
  assign unused_sig = cpl_mismatch ^ MAX_RETRY[0] ^ RETRY_DELAY[0];
`endif

  assign s_axis_rq_tdata = beat[C_DATA_WIDTH-1:0];
  assign cmd_ready       = reset_n && (state == IDLE);
  assign busy            = (state != IDLE);
  assign config_mode     = (state != IDLE) && (state != RESP);
  assign rsp_valid       = (state == RESP);
  assign rsp_status      = rsp_valid ? status_q : 3'd0;
  assign rsp_data        = rsp_valid ? data_q : 32'd0;

endmodule

// File: tb/tb_pcie_cfg_req_ctrl.sv
// Directed bench for pcie_cfg_req_ctrl; short timeout/retry parameters keep the run small.
`timescale 1ns/1ps
module tb_pcie_cfg_req_ctrl;
  localparam int CPL_TO = 40;
  localparam int MAXR   = 3;
  localparam int RDLY   = 6;

  logic         user_clk = 1'b0;
  logic         reset_n  = 1'b0;
  logic         cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_type1 = 1'b0;
  logic [15:0]  cmd_bdf = '0;
  logic [9:0]   cmd_reg = '0;
  logic [3:0]   cmd_be = '0;
  logic [31:0]  cmd_wdata = '0;
  logic [127:0] tdata;
  logic [3:0]   tkeep;
  logic         tlast, tvalid, tready = 1'b0;
  logic [59:0]  tuser;
  logic         config_mode;
  logic         cpl_sc = 1'b0, cpl_ur = 1'b0, cpl_crs = 1'b0, cpl_ca = 1'b0, cpl_mismatch = 1'b0;
  logic [31:0]  cpl_data = '0;
  logic         rsp_valid;
  logic [2:0]   rsp_status;
  logic [31:0]  rsp_data;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_tag = 8'd0;

  pcie_cfg_req_ctrl #(.CPL_TIMEOUT(CPL_TO), .MAX_RETRY(MAXR), .RETRY_DELAY(RDLY)) dut (
    .user_clk(user_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_type1(cmd_type1),
    .cmd_bdf(cmd_bdf), .cmd_reg(cmd_reg), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .s_axis_rq_tdata(tdata), .s_axis_rq_tkeep(tkeep), .s_axis_rq_tlast(tlast),
    .s_axis_rq_tvalid(tvalid), .s_axis_rq_tready(tready), .s_axis_rq_tuser(tuser),
    .config_mode(config_mode),
    .cpl_sc(cpl_sc), .cpl_ur(cpl_ur), .cpl_crs(cpl_crs), .cpl_ca(cpl_ca),
    .cpl_mismatch(cpl_mismatch), .cpl_data(cpl_data),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 user_clk = ~user_clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge user_clk);
    #1;
  endtask

  function automatic logic [127:0] hdr(input logic wr, input logic t1, input logic [15:0] bdf,
                                       input logic [9:0] rg, input logic [7:0] tg);
    return {8'h01, bdf, tg, 16'h10EE, 1'b0, 2'b10, t1, wr, 11'd1, 32'd0, 20'd0, rg, 2'b00};
  endfunction

  task automatic issue(input logic wr, input logic t1, input logic [15:0] bdf, input logic [9:0] rg,
                       input logic [3:0] be, input logic [31:0] wd);
    cmd_write = wr; cmd_type1 = t1; cmd_bdf = bdf; cmd_reg = rg; cmd_be = be; cmd_wdata = wd;
    cmd_valid = 1'b1;
    tick;
    cmd_valid = 1'b0;
  endtask

  // kind: 0 sc, 1 ur, 2 crs, 3 ca
  task automatic pulse(input int kind, input logic [31:0] d);
    cpl_sc = (kind == 0); cpl_ur = (kind == 1); cpl_crs = (kind == 2); cpl_ca = (kind == 3);
    cpl_data = d;
    tick;
    cpl_sc = 1'b0; cpl_ur = 1'b0; cpl_crs = 1'b0; cpl_ca = 1'b0; cpl_data = '0;
  endtask

  task automatic wait_tvalid(input int limit, output int gap);
    gap = 0;
    while (!tvalid && gap < limit) begin
      tick;
      gap++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge user_clk);
    #1;
    checks++; if ({tvalid, config_mode, busy, cmd_ready, rsp_valid} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000", {tvalid, config_mode, busy, cmd_ready, rsp_valid}); end
    checks++; if ({tdata, tkeep, tlast, tuser, rsp_status, rsp_data} !== '0) begin errors++; $display("FAIL reset_data: outputs not zero"); end
    reset_n = 1'b1;
    tick;
    checks++; if ({cmd_ready, busy, config_mode} !== 3'b100) begin errors++; $display("FAIL reset_release: got %b exp 100", {cmd_ready, busy, config_mode}); end
  endtask

  task automatic test_read;
    tready = 1'b1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b exp 1", cmd_ready); end
    issue(1'b0, 1'b0, 16'h0100, 10'h004, 4'hF, 32'h0);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rd_tvalid: got %b exp 1", tvalid); end
    checks++; if (tdata !== {8'h01, 16'h0100, exp_tag, 32'h10EE4001, 32'h0, 32'h00000010}) begin errors++; $display("FAIL rd_hdr: got %h exp %h", tdata, {8'h01, 16'h0100, exp_tag, 32'h10EE4001, 32'h0, 32'h00000010}); end
    checks++; if ({tkeep, tlast} !== 5'b11111) begin errors++; $display("FAIL rd_keep_last: got %b exp 11111", {tkeep, tlast}); end
    checks++; if (tuser !== 60'hF) begin errors++; $display("FAIL rd_tuser: got %h exp f", tuser); end
    checks++; if ({config_mode, busy, cmd_ready} !== 3'b110) begin errors++; $display("FAIL rd_mode: got %b exp 110", {config_mode, busy, cmd_ready}); end
    tick;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rd_one_beat: got %b exp 0", tvalid); end
    pulse(0, 32'h12345678);
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd0, 32'h12345678}) begin errors++; $display("FAIL rd_rsp: got %b/%0d/%h exp 1/0/12345678", rsp_valid, rsp_status, rsp_data); end
    tick;
    checks++; if ({rsp_valid, config_mode, cmd_ready} !== 3'b001) begin errors++; $display("FAIL rd_after: got %b exp 001", {rsp_valid, config_mode, cmd_ready}); end
    exp_tag++;
  endtask

  task automatic test_write_stall;
    logic [127:0] exp;
    tready = 1'b0;
    issue(1'b1, 1'b1, 16'h0208, 10'h041, 4'h3, 32'hDEADBEEF);
    exp = {8'h01, 16'h0208, exp_tag, 32'h10EE5801, 32'h0, 32'h00000104};
    for (int i = 0; i < 5; i++) begin
      checks++; if ({tvalid, tlast, rsp_valid} !== 3'b100 || tdata !== exp) begin errors++; $display("FAIL wr_hold%0d: got v%b l%b r%b %h exp v1 l0 r0 %h", i, tvalid, tlast, rsp_valid, tdata, exp); end
      cpl_sc = (i == 2);
      tick;
    end
    cpl_sc = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_stray_cpl: got %b exp 0", rsp_valid); end
    tready = 1'b1;
    tick;
    checks++; if ({tvalid, tkeep, tlast} !== 6'b100011 || tdata !== {96'd0, 32'hDEADBEEF}) begin errors++; $display("FAIL wr_data: got v%b k%h l%b %h", tvalid, tkeep, tlast, tdata); end
    checks++; if (tuser !== 60'h3) begin errors++; $display("FAIL wr_tuser: got %h exp 3", tuser); end
    tick;
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL wr_end: got %b exp 0", tvalid); end
    pulse(0, 32'hCAFEF00D);
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd0, 32'h0}) begin errors++; $display("FAIL wr_rsp: got %b/%0d/%h exp 1/0/0", rsp_valid, rsp_status, rsp_data); end
    tick;
    exp_tag++;
  endtask

  task automatic test_ca_ur;
    tready = 1'b1;
    issue(1'b1, 1'b0, 16'h0010, 10'h3FF, 4'h1, 32'h55);
    checks++; if (tdata !== hdr(1'b1, 1'b0, 16'h0010, 10'h3FF, exp_tag) || tdata[95:64] !== 32'h10EE4801) begin errors++; $display("FAIL wr0_hdr: got %h", tdata); end
    tick;
    tick;
    pulse(3, 32'h1234);
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd4, 32'h0}) begin errors++; $display("FAIL ca_rsp: got %b/%0d/%h exp 1/4/0", rsp_valid, rsp_status, rsp_data); end
    tick;
    exp_tag++;
    issue(1'b0, 1'b1, 16'h0A18, 10'h100, 4'hF, 32'h0);
    checks++; if (tdata !== hdr(1'b0, 1'b1, 16'h0A18, 10'h100, exp_tag) || tdata[95:64] !== 32'h10EE5001) begin errors++; $display("FAIL rd1_hdr: got %h", tdata); end
    tick;
    pulse(1, 32'hAAAA5555);
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd1, 32'h0}) begin errors++; $display("FAIL ur_rsp: got %b/%0d/%h exp 1/1/0", rsp_valid, rsp_status, rsp_data); end
    tick;
    exp_tag++;
  endtask

  task automatic test_timeout(input logic ur_at_expiry);
    int n;
    logic seen;
    tready = 1'b1;
    issue(1'b0, 1'b0, 16'h0300, 10'h010, 4'hF, 32'h0);
    tick;
    n = 0;
    seen = 1'b0;
    while (n < 200) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      cpl_mismatch = (n == 10);
      cpl_ur = ur_at_expiry && (n == CPL_TO - 1);
      tick;
      n++;
    end
    cpl_mismatch = 1'b0;
    cpl_ur = 1'b0;
    checks++; if (!seen || n != CPL_TO) begin errors++; $display("FAIL to_latency: got seen=%b cycles=%0d exp 1/%0d", seen, n, CPL_TO); end
    checks++; if ({rsp_status, rsp_data} !== {(ur_at_expiry ? 3'd1 : 3'd7), 32'h0}) begin errors++; $display("FAIL to_status: got %0d/%h exp %0d/0", rsp_status, rsp_data, ur_at_expiry ? 1 : 7); end
    tick;
    exp_tag++;
  endtask

`ifdef PCIE_CFG_CRS_RETRY_EN
  task automatic test_crs_retry;
    int gap;
    tready = 1'b1;
    issue(1'b0, 1'b0, 16'h0400, 10'h008, 4'hF, 32'h0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (tvalid !== 1'b1 || tdata !== hdr(1'b0, 1'b0, 16'h0400, 10'h008, 8'(exp_tag + i))) begin errors++; $display("FAIL crs_hdr%0d: got v%b %h", i, tvalid, tdata); end
      tick;
      pulse(2, 32'h0);
      checks++; if ({busy, config_mode, rsp_valid} !== 3'b110) begin errors++; $display("FAIL crs_wait%0d: got %b exp 110", i, {busy, config_mode, rsp_valid}); end
      wait_tvalid(100, gap);
      checks++; if (gap != RDLY) begin errors++; $display("FAIL crs_gap%0d: got %0d exp %0d", i, gap, RDLY); end
    end
    checks++; if (tdata !== hdr(1'b0, 1'b0, 16'h0400, 10'h008, 8'(exp_tag + 3))) begin errors++; $display("FAIL crs_hdr3: got %h", tdata); end
    tick;
    pulse(0, 32'h0BADCAFE);
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd0, 32'h0BADCAFE}) begin errors++; $display("FAIL crs_final: got %b/%0d/%h exp 1/0/0badcafe", rsp_valid, rsp_status, rsp_data); end
    tick;
    exp_tag = 8'(exp_tag + 4);
  endtask

  task automatic test_crs_exhaust;
    int gap;
    int hdrs;
    tready = 1'b1;
    issue(1'b0, 1'b0, 16'h0500, 10'h00C, 4'hF, 32'h0);
    hdrs = 0;
    for (int i = 0; i < 10; i++) begin
      wait_tvalid(100, gap);
      if (!tvalid) break;
      checks++; if (tdata[103:96] !== 8'(exp_tag + hdrs)) begin errors++; $display("FAIL exh_tag%0d: got %h exp %h", hdrs, tdata[103:96], 8'(exp_tag + hdrs)); end
      hdrs++;
      tick;
      pulse(2, 32'h0);
      if (rsp_valid) break;
    end
    checks++; if (hdrs != MAXR + 1) begin errors++; $display("FAIL exh_count: got %0d exp %0d", hdrs, MAXR + 1); end
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd2, 32'h0}) begin errors++; $display("FAIL exh_rsp: got %b/%0d/%h exp 1/2/0", rsp_valid, rsp_status, rsp_data); end
    tick;
    exp_tag = 8'(exp_tag + hdrs);
  endtask
`else
  task automatic test_crs_no_retry;
    tready = 1'b1;
    issue(1'b0, 1'b0, 16'h0400, 10'h008, 4'hF, 32'h0);
    checks++; if (tvalid !== 1'b1 || tdata[103:96] !== exp_tag) begin errors++; $display("FAIL crs_hdr: got v%b tag %h exp %h", tvalid, tdata[103:96], exp_tag); end
    tick;
    pulse(2, 32'h11111111);
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd2, 32'h0}) begin errors++; $display("FAIL crs_rsp: got %b/%0d/%h exp 1/2/0", rsp_valid, rsp_status, rsp_data); end
    tick;
    checks++; if ({tvalid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL crs_no_reissue: got %b exp 01", {tvalid, cmd_ready}); end
    exp_tag++;
  endtask
`endif

  task automatic test_tag_wrap;
    tready = 1'b1;
    while (exp_tag != 8'hFF) begin
      issue(1'b0, 1'b0, 16'h0001, 10'h001, 4'hF, 32'h0);
      tick;
      pulse(0, 32'h0);
      tick;
      exp_tag++;
    end
    issue(1'b0, 1'b0, 16'h0001, 10'h002, 4'hF, 32'h0);
    checks++; if (tdata[103:96] !== 8'hFF) begin errors++; $display("FAIL tag_ff: got %h exp ff", tdata[103:96]); end
    tick;
    pulse(0, 32'h0);
    tick;
    exp_tag++;
    issue(1'b0, 1'b0, 16'h0001, 10'h003, 4'hF, 32'h0);
    checks++; if (tdata[103:96] !== 8'h00) begin errors++; $display("FAIL tag_wrap: got %h exp 00", tdata[103:96]); end
    tick;
    pulse(0, 32'h0);
    tick;
    exp_tag++;
  endtask

  task automatic test_reset_mid;
    tready = 1'b0;
    issue(1'b0, 1'b0, 16'h0600, 10'h020, 4'hF, 32'h0);
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL rst_pre: got %b exp 1", tvalid); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({tvalid, config_mode, busy, cmd_ready} !== 4'b0000) begin errors++; $display("FAIL rst_async: got %b exp 0000", {tvalid, config_mode, busy, cmd_ready}); end
    tick;
    reset_n = 1'b1;
    tick;
    checks++; if ({cmd_ready, tvalid} !== 2'b10) begin errors++; $display("FAIL rst_after: got %b exp 10", {cmd_ready, tvalid}); end
    exp_tag = 8'd0;
    tready = 1'b1;
    issue(1'b0, 1'b0, 16'h0500, 10'h030, 4'hF, 32'h0);
    checks++; if (tdata !== hdr(1'b0, 1'b0, 16'h0500, 10'h030, exp_tag)) begin errors++; $display("FAIL rst_tag0: got %h", tdata); end
    tick;
    pulse(0, 32'h00C0FFEE);
    checks++; if ({rsp_valid, rsp_status, rsp_data} !== {1'b1, 3'd0, 32'h00C0FFEE}) begin errors++; $display("FAIL rst_rsp: got %b/%0d/%h", rsp_valid, rsp_status, rsp_data); end
    tick;
  endtask

  initial begin
    #1;
    test_reset;
    test_read;
    test_write_stall;
    test_ca_ur;
    test_timeout(1'b0);
    test_timeout(1'b1);
`ifdef PCIE_CFG_CRS_RETRY_EN
    test_crs_retry;
    test_crs_exhaust;
`else
    test_crs_no_retry;
`endif
    test_tag_wrap;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcie_cfg_req_ctrl.md
Name: pcie_cfg_req_ctrl

Overview:
- Root-port configuration request engine.
- Accepts one CfgRd/CfgWr command at a time from the host-side controller and builds a Type0 or Type1 config TLP on the 128-bit RQ AXI-stream.
- Holds config_mode high so the downstream completion decoder diverts the reply, then consumes the decoder's cpl_sc/cpl_ur/cpl_crs/cpl_ca/cpl_data/cpl_mismatch pulses.
- Returns a single status/data response, with timeout and CRS retry.

Parameters:
- REQUESTER_ID, 16'h10EE, requester ID placed in the descriptor; must equal the decoder's REQUESTER_ID.
- C_DATA_WIDTH, 128, RQ data width; only 128 is supported.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width.
- AXI4_RQ_TUSER_WIDTH, 60, RQ tuser width.
- CPL_TIMEOUT, 50000, cycles in WAIT_CPL before a timeout is reported.
- MAX_RETRY, 8, maximum CRS re-issues.
- RETRY_DELAY, 1024, idle cycles between a CRS completion and the re-issue.

Ports:
- user_clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = CfgWr, 0 = CfgRd.
- cmd_type1  in  1  1 = Type1, 0 = Type0.
- cmd_bdf  in  16  target bus/dev/func.
- cmd_reg  in  10  dword register number (ext[3:0], reg[5:0]).
- cmd_be  in  4  first-DW byte enables.
- cmd_wdata  in  32  write data.
- s_axis_rq_tdata  out  C_DATA_WIDTH  RQ data.
- s_axis_rq_tkeep  out  KEEP_WIDTH  RQ keep.
- s_axis_rq_tlast  out  1  RQ last.
- s_axis_rq_tvalid  out  1  RQ valid.
- s_axis_rq_tready  in  1  RQ ready.
- s_axis_rq_tuser  out  AXI4_RQ_TUSER_WIDTH  [3:0] = cmd_be, [7:4] = 0, all other bits 0.
- config_mode  out  1  to decoder; high while a command is outstanding.
- cpl_sc / cpl_ur / cpl_crs / cpl_ca / cpl_mismatch  in  1 each  decoder status pulses.
- cpl_data  in  32  decoder completion data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_status  out  3  0 = SC, 1 = UR, 2 = CRS exhausted, 4 = CA, 7 = timeout.
- rsp_data  out  32  read data; 0 for writes and for errors.
- busy  out  1  state != IDLE.

Behaviour:
- Reset:
  - reset_n low asynchronously clears all state and drives every output to 0.
  - State returns to IDLE and the tag goes to 0.
  - Assertion mid-transfer drops tvalid immediately, with no completion to the packet.
- States: IDLE, SEND_HDR, SEND_DATA, WAIT_CPL, RETRY_WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register the command, set config_mode = 1 on the next edge, and go to SEND_HDR.
- SEND_HDR: one beat, tkeep = 4'hF.
  - DW0 = {20'b0, cmd_reg, 2'b00}; DW1 = 0.
  - DW2 = {REQUESTER_ID, 1'b0, req_type[3:0], 11'd1}.
  - req_type: 1000 = CfgRd0, 1001 = CfgWr0, 1010 = CfgRd1, 1011 = CfgWr1.
  - DW3 = {1'b0, 3'b000, 3'b000, 1'b1, cmd_bdf, tag[7:0]}.
  - tlast = !cmd_write.
  - tvalid stays high and the beat stays stable until tready.
  - On the handshake, go to SEND_DATA for a write, otherwise WAIT_CPL.
- SEND_DATA: tdata[31:0] = cmd_wdata, upper bits 0, tkeep = 4'h1, tlast = 1. Go to WAIT_CPL on the handshake.
- WAIT_CPL: the timeout counter clears on entry and increments every cycle. Priority when several events coincide: completion > mismatch > timeout.
  - cpl_sc: respond status 0, rsp_data = cpl_data for reads, 0 for writes.
  - cpl_ur: respond status 1.
  - cpl_ca: respond status 4.
  - cpl_crs: if retry_cnt < MAX_RETRY, go to RETRY_WAIT; otherwise respond status 2.
  - cpl_mismatch: ignored; keep waiting and do not reset the timer.
  - Counter reaching CPL_TIMEOUT-1: respond status 7.
- RETRY_WAIT: count RETRY_DELAY cycles, increment retry_cnt, increment tag, then go to SEND_HDR.
- RESP:
  - rsp_valid high for exactly one cycle; config_mode drops on the same edge.
  - The next state is IDLE, so cmd_ready returns the cycle after rsp_valid.
- Tag: 8 bits, incremented per issued TLP including retries, wraps 255 -> 0.
- Decoder pulses outside WAIT_CPL are ignored.
- Minimum latency, read with tready held high: cmd accept -> TLP beat 1 cycle later; rsp_valid 1 cycle after the cpl pulse.

Optional Feature:
- PCIE_CFG_CRS_RETRY_EN defined: CRS retry behaves as above.
- Not defined: RETRY_WAIT is absent, and any cpl_crs immediately responds with status 2, rsp_data 0, after zero re-issues. MAX_RETRY and RETRY_DELAY are unused.

Test Plan:
- CfgRd0 bdf = 16'h0100, reg = 10'h004, be = 4'hF; tready high; cpl_sc with cpl_data = 32'h12345678 -> one beat, DW2[14:11] = 4'b1000, DW3[23:8] = 16'h0100, DW0[11:2] = 10'h004, tlast = 1; rsp_status 0, rsp_data 32'h12345678; config_mode low after rsp_valid.
- CfgWr1 wdata = 32'hDEADBEEF, tready low for 5 cycles -> header held stable; second beat tkeep = 4'h1, tdata[31:0] = 32'hDEADBEEF; cpl_sc -> rsp_status 0, rsp_data 0.
- Read answered with cpl_crs three times, then cpl_sc (retry enabled) -> four header beats with tags n..n+3, RETRY_DELAY gap before each re-issue, final rsp_status 0. With MAX_RETRY = 2 and only CRS replies -> rsp_status 2 after three TLPs.
- No completion; a cpl_mismatch pulse at cycle 10 -> rsp_status 7 exactly CPL_TIMEOUT cycles after WAIT_CPL entry; mismatch does not end the wait.
- cpl_ur on the same cycle as the timeout expiry -> rsp_status 1. Tag at 8'hFF issues then wraps to 8'h00 on the next command.
- reset_n asserted while tvalid is high in SEND_HDR -> tvalid, config_mode and busy go to 0 without waiting for a clock edge; after release cmd_ready = 1 and tag = 0.
